// File: rtl/riscv_v_adder_seq.sv
// Vector adder sequencer: walks one add-class instruction over an
// LMUL register group, driving register-file reads, adder strobes and writeback.
module riscv_v_adder_seq #(
    parameter int NUM_REGS   = 32,
    parameter int NUM_OSIZES = 4,
    parameter int MAX_LMUL   = 8,
    localparam int AW        = $clog2(NUM_REGS),
    localparam int CW        = $clog2(MAX_LMUL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [1:0]            req_osize,
    input  logic [3:0]            req_lmul,
    input  logic                  req_signed,
    input  logic                  req_use_carry,
    input  logic [AW-1:0]         req_vd,
    input  logic [AW-1:0]         req_vs1,
    input  logic [AW-1:0]         req_vs2,
    input  logic                  flush,
    output logic                  rf_rd_en,
    output logic [AW-1:0]         rf_rd_addr_a,
    output logic [AW-1:0]         rf_rd_addr_b,
    output logic                  add_valid,
    output logic [3:0]            add_op,
    output logic                  add_signed,
    output logic                  add_use_carry,
    output logic                  add_is_reduct,
    output logic [NUM_OSIZES-1:0] add_osize_vector,
    output logic [NUM_OSIZES-1:0] add_greater_osize_vector,
    output logic                  acc_sel,
    output logic                  acc_load,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [AW-1:0]         wb_addr,
    output logic                  done_valid,
    output logic                  done_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        EX,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   chunk_cnt;
    logic [3:0]      op_q;
    logic [1:0]      osize_q;
    logic [3:0]      lmul_q;
    logic            signed_q;
    logic            carry_q;
    logic [AW-1:0]   vd_q;
    logic [AW-1:0]   vs1_q;
    logic [AW-1:0]   vs2_q;
    logic            err_q;

    logic            req_red;
    logic            req_bad;
    logic [AW-1:0]   lmul_mask;
    logic            red_q;
    logic            last_chunk;
    logic            wb_chunk;

    // Classify the incoming request: reductions and illegal encodings/alignments
    always_comb begin
        req_red   = (req_op >= 4'd8) && (req_op <= 4'd10);
        lmul_mask = AW'(req_lmul - 4'd1);
        req_bad   = 1'b0;
        if (req_op > 4'd10)
            req_bad = 1'b1;
        if (!(req_lmul inside {4'd1, 4'd2, 4'd4, 4'd8}))
            req_bad = 1'b1;
        if ((req_vs2 & lmul_mask) != '0)
            req_bad = 1'b1;
        if (!req_red && (((req_vd & lmul_mask) != '0) ||
                         ((req_vs1 & lmul_mask) != '0)))
            req_bad = 1'b1;
    end

    assign red_q      = (op_q >= 4'd8) && (op_q <= 4'd10);
    assign last_chunk = (4'(chunk_cnt) == (lmul_q - 4'd1));
    assign wb_chunk   = !red_q || last_chunk;

    // Sequencer state, chunk counter and latched instruction fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            chunk_cnt <= '0;
            op_q      <= '0;
            osize_q   <= '0;
            lmul_q    <= '0;
            signed_q  <= 1'b0;
            carry_q   <= 1'b0;
            vd_q      <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            err_q     <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            chunk_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        osize_q   <= req_osize;
                        lmul_q    <= req_lmul;
                        signed_q  <= req_signed;
                        carry_q   <= req_use_carry;
                        vd_q      <= req_vd;
                        vs1_q     <= req_vs1;
                        vs2_q     <= req_vs2;
                        err_q     <= req_bad;
                        chunk_cnt <= '0;
                        state     <= req_bad ? DONE : RD;
                    end
                end
                RD: state <= EX;
                EX: begin
                    if (!wb_chunk || wb_ready) begin
                        if (last_chunk) begin
                            state <= DONE;
                        end else begin
                            chunk_cnt <= chunk_cnt + CW'(1);
                            state     <= RD;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from state and latched fields; strobes drop during flush
    always_comb begin
        req_ready                = (state == IDLE) && !flush && !rst;
        busy                     = (state != IDLE);
        rf_rd_en                 = 1'b0;
        rf_rd_addr_a             = '0;
        rf_rd_addr_b             = '0;
        add_valid                = 1'b0;
        add_op                   = '0;
        add_signed               = 1'b0;
        add_use_carry            = 1'b0;
        add_is_reduct            = 1'b0;
        add_osize_vector         = '0;
        add_greater_osize_vector = '0;
        acc_sel                  = 1'b0;
        acc_load                 = 1'b0;
        wb_valid                 = 1'b0;
        wb_addr                  = '0;
        done_valid               = 1'b0;
        done_err                 = 1'b0;
        unique case (state)
            RD: begin
                rf_rd_en     = !flush;
                rf_rd_addr_b = vs2_q + AW'(chunk_cnt);
                if (!red_q)
                    rf_rd_addr_a = vs1_q + AW'(chunk_cnt);
                else if (chunk_cnt == '0)
                    rf_rd_addr_a = vs1_q;
            end
            EX: begin
                add_valid     = !flush;
                add_op        = op_q;
                add_signed    = signed_q;
                add_use_carry = carry_q;
                add_is_reduct = red_q;
                for (int i = 0; i < NUM_OSIZES; i++) begin
                    add_osize_vector[i]         = (i == int'(osize_q));
                    add_greater_osize_vector[i] = (i > int'(osize_q));
                end
                acc_sel  = red_q && (chunk_cnt != '0);
                acc_load = !wb_chunk && !flush;
                wb_valid = wb_chunk && !flush;
                if (wb_chunk)
                    wb_addr = red_q ? vd_q : vd_q + AW'(chunk_cnt);
            end
            DONE: begin
                done_valid = !flush;
                done_err   = err_q && !flush;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_v_adder_seq.sv
// Directed bench for riscv_v_adder_seq: vector table plus
// cycle-exact sequences for stall, reduction, flush and reset.
module tb_riscv_v_adder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [1:0] req_osize;
    logic [3:0] req_lmul;
    logic       req_signed;
    logic       req_use_carry;
    logic [4:0] req_vd, req_vs1, req_vs2;
    logic       flush;
    logic       rf_rd_en;
    logic [4:0] rf_rd_addr_a, rf_rd_addr_b;
    logic       add_valid;
    logic [3:0] add_op;
    logic       add_signed, add_use_carry, add_is_reduct;
    logic [3:0] add_osize_vector, add_greater_osize_vector;
    logic       acc_sel, acc_load;
    logic       wb_valid, wb_ready;
    logic [4:0] wb_addr;
    logic       done_valid, done_err, busy;

    riscv_v_adder_seq dut (
        .clk                      (clk),
        .rst                      (rst),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_op                   (req_op),
        .req_osize                (req_osize),
        .req_lmul                 (req_lmul),
        .req_signed               (req_signed),
        .req_use_carry            (req_use_carry),
        .req_vd                   (req_vd),
        .req_vs1                  (req_vs1),
        .req_vs2                  (req_vs2),
        .flush                    (flush),
        .rf_rd_en                 (rf_rd_en),
        .rf_rd_addr_a             (rf_rd_addr_a),
        .rf_rd_addr_b             (rf_rd_addr_b),
        .add_valid                (add_valid),
        .add_op                   (add_op),
        .add_signed               (add_signed),
        .add_use_carry            (add_use_carry),
        .add_is_reduct            (add_is_reduct),
        .add_osize_vector         (add_osize_vector),
        .add_greater_osize_vector (add_greater_osize_vector),
        .acc_sel                  (acc_sel),
        .acc_load                 (acc_load),
        .wb_valid                 (wb_valid),
        .wb_ready                 (wb_ready),
        .wb_addr                  (wb_addr),
        .done_valid               (done_valid),
        .done_err                 (done_err),
        .busy                     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [1:0] os;
        logic [3:0] lmul;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        bit         err;
        int         n;
        int         wbs;
        int         accs;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] lmul,
                         input logic [4:0] vd, input logic [4:0] vs1,
                         input logic [4:0] vs2);
        req_op    = op;
        req_osize = 2'd2;
        req_lmul  = lmul;
        req_vd    = vd;
        req_vs1   = vs1;
        req_vs2   = vs2;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  n, wbs, accs, rds;
        bit  red;
        red = (v.op >= 8) && (v.op <= 10);
        wb_ready = 1'b1;
        chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 1);
        req_op        = v.op;
        req_osize     = v.os;
        req_lmul      = v.lmul;
        req_vd        = v.vd;
        req_vs1       = v.vs1;
        req_vs2       = v.vs2;
        req_signed    = 1'b1;
        req_use_carry = 1'b0;
        req_valid     = 1'b1;
        tick;
        req_valid = 1'b0;
        n = 1; wbs = 0; accs = 0; rds = 0;
        while (!done_valid && n < 64) begin
            if (rf_rd_en) begin
                chk($sformatf("v%0d rd_addr_b", idx), 32'(rf_rd_addr_b),
                    32'(v.vs2) + 32'(rds));
                rds++;
            end
            if (wb_valid) begin
                chk($sformatf("v%0d wb_addr", idx), 32'(wb_addr),
                    red ? 32'(v.vd) : 32'(v.vd) + 32'(wbs));
                wbs++;
            end
            if (acc_load)
                accs++;
            tick;
            n++;
        end
        chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.n));
        chk($sformatf("v%0d done_err", idx), 32'(done_err), 32'(v.err));
        chk($sformatf("v%0d wb count", idx), 32'(wbs), 32'(v.wbs));
        chk($sformatf("v%0d acc_load count", idx), 32'(accs), 32'(v.accs));
        chk($sformatf("v%0d rd count", idx), 32'(rds),
            v.err ? 32'd0 : 32'(v.lmul));
        tick;
        chk($sformatf("v%0d idle busy", idx), 32'(busy), 0);
    endtask

    vec_t vecs[12];
    int   cnt;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_osize = '0;
        req_lmul = 4'd1; req_signed = 1'b0; req_use_carry = 1'b0;
        req_vd = '0; req_vs1 = '0; req_vs2 = '0; flush = 1'b0;
        wb_ready = 1'b1;

        vecs[0]  = '{4'd0,  2'd2, 4'd1, 5'd3,  5'd1,  5'd2,  0, 3,  1, 0};
        vecs[1]  = '{4'd1,  2'd0, 4'd4, 5'd8,  5'd4,  5'd12, 0, 9,  4, 0};
        vecs[2]  = '{4'd8,  2'd3, 4'd8, 5'd7,  5'd5,  5'd16, 0, 17, 1, 7};
        vecs[3]  = '{4'd3,  2'd1, 4'd2, 5'd2,  5'd4,  5'd6,  0, 5,  2, 0};
        vecs[4]  = '{4'd6,  2'd0, 4'd1, 5'd31, 5'd30, 5'd29, 0, 3,  1, 0};
        vecs[5]  = '{4'd10, 2'd2, 4'd4, 5'd3,  5'd5,  5'd4,  0, 9,  1, 3};
        vecs[6]  = '{4'd12, 2'd0, 4'd1, 5'd1,  5'd2,  5'd3,  1, 1,  0, 0};
        vecs[7]  = '{4'd0,  2'd0, 4'd3, 5'd0,  5'd0,  5'd0,  1, 1,  0, 0};
        vecs[8]  = '{4'd0,  2'd0, 4'd4, 5'd2,  5'd4,  5'd8,  1, 1,  0, 0};
        vecs[9]  = '{4'd9,  2'd0, 4'd2, 5'd1,  5'd1,  5'd3,  1, 1,  0, 0};
        vecs[10] = '{4'd4,  2'd0, 4'd8, 5'd8,  5'd9,  5'd16, 1, 1,  0, 0};
        vecs[11] = '{4'd7,  2'd1, 4'd2, 5'd30, 5'd0,  5'd2,  0, 5,  2, 0};

        #1;
        chk("reset req_ready", 32'(req_ready), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset wb_valid", 32'(wb_valid), 0);
        tick;
        rst = 1'b0;
        #1;
        chk("post-reset req_ready", 32'(req_ready), 1);

        foreach (vecs[i])
            run_vec(vecs[i], i);

        // ADD osize=2 lmul=1: cycle-exact timing and decodes
        req_signed = 1'b0;
        issue(4'd0, 4'd1, 5'd3, 5'd1, 5'd2);
        chk("add T1 rd_en", 32'(rf_rd_en), 1);
        chk("add T1 addr_a", 32'(rf_rd_addr_a), 1);
        chk("add T1 addr_b", 32'(rf_rd_addr_b), 2);
        chk("add T1 add_valid", 32'(add_valid), 0);
        tick;
        chk("add T2 add_valid", 32'(add_valid), 1);
        chk("add T2 osize_vec", 32'(add_osize_vector), 32'b0100);
        chk("add T2 greater", 32'(add_greater_osize_vector), 32'b1000);
        chk("add T2 wb_addr", 32'(wb_addr), 3);
        chk("add T2 wb_valid", 32'(wb_valid), 1);
        tick;
        chk("add T3 done", 32'({done_valid, done_err}), 32'b10);
        tick;
        chk("add T4 req_ready", 32'(req_ready), 1);

        // REDSUM lmul=8: accumulator select/load per chunk
        issue(4'd8, 4'd8, 5'd7, 5'd5, 5'd16);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("red c%0d addr_b", k), 32'(rf_rd_addr_b), 32'(16 + k));
            chk($sformatf("red c%0d addr_a", k), 32'(rf_rd_addr_a),
                k == 0 ? 32'd5 : 32'd0);
            tick;
            chk($sformatf("red c%0d acc_sel", k), 32'(acc_sel), 32'(k != 0));
            chk($sformatf("red c%0d acc_load", k), 32'(acc_load), 32'(k != 7));
            chk($sformatf("red c%0d wb_valid", k), 32'(wb_valid), 32'(k == 7));
            chk($sformatf("red c%0d is_reduct", k), 32'(add_is_reduct), 1);
            if (k == 7)
                chk("red wb_addr", 32'(wb_addr), 7);
            tick;
        end
        chk("red done", 32'(done_valid), 1);
        tick;

        // ADD lmul=2 with wb_ready low for 3 cycles on chunk 0
        wb_ready = 1'b0;
        issue(4'd0, 4'd2, 5'd4, 5'd2, 5'd6);
        tick;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("stall%0d wb", s), 32'({add_valid, wb_valid}), 32'b11);
            chk($sformatf("stall%0d wb_addr", s), 32'(wb_addr), 4);
            tick;
        end
        wb_ready = 1'b1;
        #1;
        chk("stall release wb_addr", 32'(wb_addr), 4);
        tick;
        chk("stall c1 rd addr_b", 32'(rf_rd_addr_b), 7);
        tick;
        chk("stall c1 wb_addr", 32'(wb_addr), 5);
        tick;
        chk("stall done", 32'(done_valid), 1);
        tick;

        // Flush in EX of chunk 1 of an lmul=4 SUB
        issue(4'd1, 4'd4, 5'd8, 5'd4, 5'd12);
        tick; tick; tick;
        chk("flush pre wb_addr", 32'(wb_addr), 9);
        flush = 1'b1;
        #1;
        chk("flush strobes", 32'({add_valid, wb_valid, rf_rd_en}), 0);
        chk("flush req_ready", 32'(req_ready), 0);
        tick;
        flush = 1'b0;
        #1;
        chk("flush idle", 32'({busy, req_ready}), 32'b01);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (done_valid)
                cnt++;
            tick;
        end
        chk("flush no done", 32'(cnt), 0);

        // Flush with req_valid in IDLE must not accept
        flush = 1'b1;
        req_valid = 1'b1;
        tick;
        flush = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("flush idle no accept", 32'(busy), 0);

        // Reset asserted during RD clears outputs immediately
        issue(4'd0, 4'd1, 5'd3, 5'd1, 5'd2);
        chk("pre-rst rd_en", 32'(rf_rd_en), 1);
        rst = 1'b1;
        #1;
        chk("rst rd_en", 32'(rf_rd_en), 0);
        chk("rst addr_b", 32'(rf_rd_addr_b), 0);
        chk("rst busy/ready", 32'({busy, req_ready}), 0);
        tick;
        rst = 1'b0;
        #1;
        chk("rst release ready", 32'(req_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
